seg7_scan_driver: RTL



---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_scan_driver_if.sv | 24 ++
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 99 +++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed seven-segment driver.
//   HEX7     - active-low g..a patterns for nibbles 0..F (index = nibble)
//   SEG_OFF  - cathode word with every segment and the dp dark
//   AN_OFF   - anode word with every digit disabled
//   DIGIT_W  - width of the digit index (8 digits)
package seg7_pkg;

  localparam int DIGIT_W = 3;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Packed so index 0 is the rightmost element of the concatenation.
  localparam logic [15:0][6:0] HEX7 = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display-word input side and panel output side.
//   data_in  [31:0] display word, nibble k -> digit k (digit 0 rightmost)
//   dp_in    [7:0]  decimal point enables, bit k -> digit k
//   blank_lz        1 = blank leading-zero digits
//   seg_an   [7:0]  digit anodes, active low
//   seg_out  [7:0]  cathodes, active low, [7]=dp, [6:0]=g..a
// master: the side supplying data (bridge / bench); slave: the driver.
interface seg7_scan_driver_if;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  modport master (
    output data_in, dp_in, blank_lz,
    input  seg_an, seg_out
  );

  modport slave (
    input  data_in, dp_in, blank_lz,
    output seg_an, seg_out
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to active-low seven-segment pattern.
//   nibble_i [3:0]  hex digit
//   seg_o    [6:0]  g,f,e,d,c,b,a, active low
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX7[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 8-digit multiplexed seven-segment scan driver.
//   clk    system clock, all state on posedge
//   rst_n  synchronous active-low reset
//   bus    slave side of seg7_scan_driver_if (data_in, dp_in, blank_lz in;
//          seg_an, seg_out out)
// Each digit owns SCAN_DIV cycles; the first BLANK_CYC of those keep all
// anodes off so the previous digit's pattern cannot ghost onto the next.
// The display word is captured only as digit 7's slot ends, so a frame is
// never drawn from two different words.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 16,
  parameter int NUM_DIGITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] idx_q, idx_d;
  logic [31:0]        shadow_data_q, shadow_data_d;
  logic [7:0]         shadow_dp_q, shadow_dp_d;
  logic [7:0]         seg_an_q, seg_an_d;
  logic [7:0]         seg_out_q, seg_out_d;

  logic       tick;
  logic       frame_end;
  logic [7:0] lz_mask;
  logic [3:0] nibble;
  logic [6:0] seg_pat;
  logic       digit_off;

  assign tick      = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx_q == DIGIT_W'(NUM_DIGITS - 1));

  // Walk from the top nibble down; a digit is blanked while every nibble
  // from it upward is zero. Digit 0 always stays lit so zero shows "0".
  always_comb begin
    logic run_zero;
    lz_mask  = '0;
    run_zero = 1'b1;
    for (int k = 7; k >= 0; k--) begin
      run_zero   = run_zero & (shadow_data_q[4*k +: 4] == 4'h0);
      lz_mask[k] = bus.blank_lz & run_zero & (k != 0);
    end
  end

  assign nibble = shadow_data_q[{idx_q, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .nibble_i (nibble),
    .seg_o    (seg_pat)
  );

  assign digit_off = (cnt_q < CNT_W'(BLANK_CYC)) || lz_mask[idx_q];

  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    if (tick) begin
      idx_d = (idx_q == DIGIT_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      shadow_data_d = bus.data_in;
      shadow_dp_d   = bus.dp_in;
    end
    seg_an_d  = digit_off ? AN_OFF  : ~(8'b1 << idx_q);
    seg_out_d = digit_off ? SEG_OFF : {~shadow_dp_q[idx_q], seg_pat};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      seg_an_q      <= AN_OFF;
      seg_out_q     <= SEG_OFF;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      seg_an_q      <= seg_an_d;
      seg_out_q     <= seg_out_d;
    end
  end

  assign bus.seg_an  = seg_an_q;
  assign bus.seg_out = seg_out_q;

endmodule
